vga_timing_receiver: RTL and testbench



---
 rtl/vga_timing_receiver.sv | 169 ++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_receiver.sv
// Sink-side VGA timing recovery: synchronizes hsync/vsync, rebuilds pixel coordinates,
// and verifies line/frame timing to report lock and timing errors.
module vga_timing_receiver #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    output logic [9:0] x_o,
    output logic [8:0] y_o,
    output logic       active_video_o,
    output logic       frame_start_o,
    output logic       locked_o,
    output logic       error_o
);

    localparam logic [10:0] C_H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_H_TMO  = 11'(2 * H_TOTAL - 1);
    localparam logic [10:0] C_HS_W   = 11'(H_SYNC);
    localparam logic [10:0] C_HA_BEG = 11'(H_SYNC + H_BP);
    localparam logic [10:0] C_HA_END = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0]  C_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_VA_BEG = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  C_VA_END = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [2:0]  C_LOCK_N = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCKED} state_t;

    state_t      r_state;
    logic [2:0]  r_good_cnt;
    logic        r_hs_m, r_hs_s, r_hs_h;
    logic        r_vs_m, r_vs_s, r_vs_h;
    logic [10:0] r_h_cnt, r_hs_w;
    logic [9:0]  r_v_cnt;
    logic        r_v_pend, r_frame_ok, r_line_valid, r_have_fs;
    logic        r_frame_start, r_locked, r_error;

    logic w_hs_fall, w_hs_rise, w_vs_fall, w_fs, w_timeout;
    logic w_period_bad, w_width_bad, w_frame_good, w_active;

    // Sync flops idle high so reset release cannot fabricate an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hs_m <= 1'b1; r_hs_s <= 1'b1; r_hs_h <= 1'b1;
            r_vs_m <= 1'b1; r_vs_s <= 1'b1; r_vs_h <= 1'b1;
        end else begin
            r_hs_m <= hsync_i; r_hs_s <= r_hs_m; r_hs_h <= r_hs_s;
            r_vs_m <= vsync_i; r_vs_s <= r_vs_m; r_vs_h <= r_vs_s;
        end
    end

    always_comb begin
        w_hs_fall    = ~r_hs_s & r_hs_h;
        w_hs_rise    = r_hs_s & ~r_hs_h;
        w_vs_fall    = ~r_vs_s & r_vs_h;
        w_fs         = w_hs_fall & (r_v_pend | w_vs_fall);
        w_timeout    = (r_h_cnt == C_H_TMO);
        w_period_bad = w_hs_fall & r_line_valid & (r_h_cnt != C_H_LAST);
        w_width_bad  = w_hs_rise & (r_hs_w != C_HS_W);
        // The line closing at this fs still belongs to the ending frame.
        w_frame_good = r_have_fs & r_frame_ok & ~w_period_bad & (r_v_cnt == C_V_LAST);
        w_active     = (r_state == S_LOCKED)
                     && (r_h_cnt >= C_HA_BEG) && (r_h_cnt < C_HA_END)
                     && (r_v_cnt >= C_VA_BEG) && (r_v_cnt < C_VA_END);
        x_o = '0;
        y_o = '0;
        if (w_active) begin
            x_o = 10'(r_h_cnt - C_HA_BEG);
            y_o = 9'(r_v_cnt - C_VA_BEG);
        end
    end

    assign active_video_o = w_active;
    assign frame_start_o  = r_frame_start;
    assign locked_o       = r_locked;
    assign error_o        = r_error;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_h_cnt      <= '0;
            r_hs_w       <= '0;
            r_v_cnt      <= '0;
            r_v_pend     <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_line_valid <= 1'b0;
            r_have_fs    <= 1'b0;
        end else begin
            if (w_hs_fall)           r_h_cnt <= '0;
            else if (r_h_cnt != '1)  r_h_cnt <= r_h_cnt + 11'd1;

            if (w_hs_fall)                     r_hs_w <= 11'd1;
            else if (!r_hs_s && r_hs_w != '1)  r_hs_w <= r_hs_w + 11'd1;

            if (w_fs) begin
                r_v_cnt  <= '0;
                r_v_pend <= 1'b0;
            end else begin
                if (w_hs_fall && r_v_cnt != '1) r_v_cnt <= r_v_cnt + 10'd1;
                if (w_vs_fall)                  r_v_pend <= 1'b1;
            end

            if (w_fs)                            r_frame_ok <= 1'b1;
            else if (w_period_bad | w_width_bad) r_frame_ok <= 1'b0;

            if (w_timeout) begin
                r_line_valid <= 1'b0;
                r_have_fs    <= 1'b0;
            end else begin
                if (w_hs_fall) r_line_valid <= 1'b1;
                if (w_fs)      r_have_fs    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_SEARCH;
            r_good_cnt    <= '0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_frame_start <= w_fs;
            r_locked      <= (r_state == S_LOCKED);
            r_error       <= 1'b0;
            case (r_state)
                S_SEARCH: begin
                    if (!w_timeout && w_fs) begin
                        r_state    <= S_VERIFY;
                        r_good_cnt <= '0;
                    end
                end
                S_VERIFY: begin
                    if (w_timeout) begin
                        r_state <= S_SEARCH;
                    end else if (w_fs) begin
                        if (w_frame_good) begin
                            r_good_cnt <= r_good_cnt + 3'd1;
                            if (r_good_cnt + 3'd1 >= C_LOCK_N) r_state <= S_LOCKED;
                        end else begin
                            r_good_cnt <= '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_timeout) begin
                        r_state <= S_SEARCH;
                        r_error <= 1'b1;
                    end else if (w_period_bad || w_width_bad || (w_fs && !w_frame_good)) begin
                        r_state    <= S_VERIFY;
                        r_good_cnt <= '0;
                        r_error    <= 1'b1;
                    end
                end
                default: r_state <= S_SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a scaled-down raster (30x14) to keep runs short.
// Sample index j within a line is taken at the negedge before driving; h_cnt there is j-3.
module tb_vga_timing_receiver;

    localparam int H_ACTIVE = 16;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int H_TOTAL  = 30;
    localparam int V_ACTIVE = 6;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int V_TOTAL  = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync, vsync;
    logic [9:0] x_o;
    logic [8:0] y_o;
    logic       active_video_o, frame_start_o, locked_o, error_o;

    int n_checks = 0;
    int n_fail   = 0;
    int g_fs_cnt = 0;
    int g_err_cnt = 0;
    int cur_l = 0;

    logic       fr_av  [0:15][0:127];
    logic       fr_fs  [0:15][0:127];
    logic       fr_lk  [0:15][0:127];
    logic       fr_err [0:15][0:127];
    logic [9:0] fr_x   [0:15][0:127];
    logic [8:0] fr_y   [0:15][0:127];

    vga_timing_receiver #(
        .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
        .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
        .LOCK_FRAMES(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync),
        .x_o(x_o), .y_o(y_o), .active_video_o(active_video_o),
        .frame_start_o(frame_start_o), .locked_o(locked_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_line(input int total, input int hlow, input int vj, input logic vv);
        for (int j = 0; j < total; j++) begin
            @(negedge clk);
            fr_av[cur_l][j]  = active_video_o;
            fr_fs[cur_l][j]  = frame_start_o;
            fr_lk[cur_l][j]  = locked_o;
            fr_err[cur_l][j] = error_o;
            fr_x[cur_l][j]   = x_o;
            fr_y[cur_l][j]   = y_o;
            if (frame_start_o) g_fs_cnt++;
            if (error_o) g_err_cnt++;
            if (j == 0) hsync = 1'b0;
            if (j == hlow) hsync = 1'b1;
            if (j == vj) vsync = vv;
        end
    endtask

    // vsync falls with line 0's hsync unless last_vs_j moves it into the final line.
    task automatic run_frame(input int nlines, input int bad_l, input int bad_tot,
                             input int bad_hlow, input int last_vs_j);
        int tot, hl, vj;
        logic vv;
        for (int l = 0; l < nlines; l++) begin
            tot = (l == bad_l) ? bad_tot : H_TOTAL;
            hl  = (l == bad_l) ? bad_hlow : H_SYNC;
            vj  = -1;
            vv  = 1'b1;
            if (l == 0) begin vj = 0; vv = 1'b0; end
            else if (l == V_SYNC) begin vj = 0; vv = 1'b1; end
            else if (l == nlines - 1 && last_vs_j >= 0) begin vj = last_vs_j; vv = 1'b0; end
            cur_l = l;
            run_line(tot, hl, vj, vv);
        end
    endtask

    task automatic normal_frame();
        run_frame(V_TOTAL, -1, 0, 0, -1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_locked", locked_o, 0);
        check("rst_active", active_video_o, 0);
        check("rst_x", x_o, 0);
        check("rst_y", y_o, 0);
        check("rst_fs", frame_start_o, 0);
        check("rst_err", error_o, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Initial lock: fs1 -> VERIFY, fs2 -> 1 good, fs3 -> LOCKED
        g_fs_cnt = 0; g_err_cnt = 0;
        normal_frame();
        check("a_fs_j2", fr_fs[0][2], 0);
        check("a_fs_j3", fr_fs[0][3], 1);
        check("a_fs_j4", fr_fs[0][4], 0);
        normal_frame();
        check("b_lk", fr_lk[0][4], 0);
        check("b_av_unlocked", fr_av[5][10], 0);
        normal_frame();
        check("c_fs", fr_fs[0][3], 1);
        check("c_lk_j3", fr_lk[0][3], 0);
        check("c_lk_j4", fr_lk[0][4], 1);
        check("c_av_before", fr_av[5][9], 0);
        check("c_av_first", fr_av[5][10], 1);
        check("c_x_first", fr_x[5][10], 0);
        check("c_y_first", fr_y[5][10], 0);
        check("c_x_mid", fr_x[7][17], 7);
        check("c_y_mid", fr_y[7][17], 2);
        check("c_av_last", fr_av[10][25], 1);
        check("c_x_last", fr_x[10][25], 15);
        check("c_y_last", fr_y[10][25], 5);
        check("c_av_after_h", fr_av[10][26], 0);
        check("c_x_after_h", fr_x[10][26], 0);
        check("c_av_after_v", fr_av[11][10], 0);
        check("init_fs_cnt", g_fs_cnt, 3);
        check("init_err_cnt", g_err_cnt, 0);

        // Line of H_TOTAL+1 while locked
        g_err_cnt = 0;
        run_frame(V_TOTAL, 7, H_TOTAL + 1, H_SYNC, -1);
        check("per_err_j2", fr_err[8][2], 0);
        check("per_err_j3", fr_err[8][3], 1);
        check("per_err_j4", fr_err[8][4], 0);
        check("per_lk_j3", fr_lk[8][3], 1);
        check("per_lk_j4", fr_lk[8][4], 0);
        normal_frame();
        check("per_e_lk", fr_lk[0][4], 0);
        normal_frame();
        check("per_f_lk", fr_lk[0][4], 0);
        check("per_f_av", fr_av[5][10], 0);
        normal_frame();
        check("per_g_relock", fr_lk[0][4], 1);
        check("per_err_cnt", g_err_cnt, 1);

        // hsync pulse one clock short while locked
        g_err_cnt = 0;
        run_frame(V_TOTAL, 6, H_TOTAL, H_SYNC - 1, -1);
        check("wid_err_j5", fr_err[6][5], 0);
        check("wid_err_j6", fr_err[6][6], 1);
        check("wid_lk_j6", fr_lk[6][6], 1);
        check("wid_lk_j7", fr_lk[6][7], 0);
        check("wid_av_after", fr_av[7][10], 0);
        normal_frame();
        check("wid_i_av", fr_av[5][10], 0);
        normal_frame();
        check("wid_j_lk", fr_lk[0][4], 0);
        normal_frame();
        check("wid_k_relock", fr_lk[0][4], 1);
        check("wid_err_cnt", g_err_cnt, 1);

        // Short and long frames
        g_err_cnt = 0;
        run_frame(V_TOTAL - 1, -1, 0, 0, -1);
        normal_frame();
        check("vs_err_j3", fr_err[0][3], 1);
        check("vs_err_j4", fr_err[0][4], 0);
        check("vs_lk_j3", fr_lk[0][3], 1);
        check("vs_lk_j4", fr_lk[0][4], 0);
        normal_frame();
        check("vs_n_lk", fr_lk[0][4], 0);
        normal_frame();
        check("vs_o_relock", fr_lk[0][4], 1);
        run_frame(V_TOTAL + 1, -1, 0, 0, -1);
        normal_frame();
        check("vl_err_j3", fr_err[0][3], 1);
        check("vl_lk_j4", fr_lk[0][4], 0);
        normal_frame();
        normal_frame();
        check("vl_relock", fr_lk[0][4], 1);
        check("v_err_cnt", g_err_cnt, 2);

        // hsync held high past 2*H_TOTAL: timeout back to SEARCH
        g_err_cnt = 0;
        run_frame(V_TOTAL, 4, H_SYNC + 2 * H_TOTAL + 2, H_SYNC, -1);
        check("tmo_err_j62", fr_err[4][62], 0);
        check("tmo_err_j63", fr_err[4][63], 1);
        check("tmo_lk_j63", fr_lk[4][63], 1);
        check("tmo_lk_j64", fr_lk[4][64], 0);
        normal_frame();
        check("tmo_u_lk", fr_lk[0][4], 0);
        normal_frame();
        check("tmo_v_lk", fr_lk[0][4], 0);
        normal_frame();
        check("tmo_w_relock", fr_lk[0][4], 1);
        check("tmo_err_cnt", g_err_cnt, 1);

        // Coincident vs. mid-line vsync fall
        g_fs_cnt = 0; g_err_cnt = 0;
        run_frame(V_TOTAL, -1, 0, 0, 12);
        check("co_fs_j2", fr_fs[0][2], 0);
        check("co_fs_j3", fr_fs[0][3], 1);
        check("mid_no_fs", fr_fs[V_TOTAL - 1][15], 0);
        normal_frame();
        check("mid_fs_j2", fr_fs[0][2], 0);
        check("mid_fs_j3", fr_fs[0][3], 1);
        check("mid_still_lk", fr_lk[0][4], 1);
        check("mid_fs_cnt", g_fs_cnt, 2);
        check("mid_err_cnt", g_err_cnt, 0);

        // Reset mid-frame while locked and active
        run_frame(7, -1, 0, 0, -1);
        cur_l = 7;
        run_line(15, H_SYNC, -1, 1'b1);
        check("pre_rst_av", fr_av[7][14], 1);
        check("pre_rst_x", fr_x[7][14], 4);
        check("pre_rst_y", fr_y[7][14], 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_locked", locked_o, 0);
        check("mid_rst_active", active_video_o, 0);
        check("mid_rst_x", x_o, 0);
        check("mid_rst_y", y_o, 0);
        check("mid_rst_fs", frame_start_o, 0);
        check("mid_rst_err", error_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        g_fs_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_start_o) g_fs_cnt++;
        end
        check("rel_no_fs", g_fs_cnt, 0);
        normal_frame();
        check("rel_fs1", fr_fs[0][3], 1);
        normal_frame();
        check("rel_lk2", fr_lk[0][4], 0);
        normal_frame();
        check("rel_lk3", fr_lk[0][4], 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
